// File: rtl/fsm_flow_ctrl.sv
// Flow-control FSM for the two-virtual-channel FIFO datapath: captures and validates
// FIFO thresholds, tracks idle/active traffic and latches FIFO error flags.
module fsm_flow_ctrl #(
    parameter int W = 5,
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic [W-1:0] main_fifo_low,
    input  logic [W-1:0] Vco_low,
    input  logic [W-1:0] Vc1_low,
    input  logic [W-1:0] Do_low,
    input  logic [W-1:0] D1_low,
    input  logic [W-1:0] main_fifo_high,
    input  logic [W-1:0] Vco_high,
    input  logic [W-1:0] Vc1_high,
    input  logic [W-1:0] Do_high,
    input  logic [W-1:0] D1_high,
    input  logic [N-1:0] empties,
    input  logic [N-1:0] errors,
    output logic [W-1:0] main_fifo_low_out,
    output logic [W-1:0] Vco_low_out,
    output logic [W-1:0] Vc1_low_out,
    output logic [W-1:0] Do_low_out,
    output logic [W-1:0] D1_low_out,
    output logic [W-1:0] main_fifo_high_out,
    output logic [W-1:0] Vco_high_out,
    output logic [W-1:0] Vc1_high_out,
    output logic [W-1:0] Do_high_out,
    output logic [W-1:0] D1_high_out,
    output logic [4:0]   state,
    output logic         cfg_err,
    output logic         idle_out,
    output logic         active_out,
    output logic [N-1:0] error_out
);

    localparam int NP = 5;

    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    state_t         state_reg;
    logic [N-1:0]   error_reg;
    logic [W-1:0]   low_reg  [NP];
    logic [W-1:0]   high_reg [NP];
    logic [W-1:0]   low_in   [NP];
    logic [W-1:0]   high_in  [NP];
    logic [NP-1:0]  pair_ok;
    logic           all_valid;
    logic           any_err;
    logic           all_empty;

    // Pair index order matches the empties/errors bit order: main, VC0, VC1, D0, D1.
    assign low_in[0]  = main_fifo_low;
    assign low_in[1]  = Vco_low;
    assign low_in[2]  = Vc1_low;
    assign low_in[3]  = Do_low;
    assign low_in[4]  = D1_low;
    assign high_in[0] = main_fifo_high;
    assign high_in[1] = Vco_high;
    assign high_in[2] = Vc1_high;
    assign high_in[3] = Do_high;
    assign high_in[4] = D1_high;

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_pair
            assign pair_ok[gi] = (low_in[gi] <= high_in[gi]);
        end
    endgenerate

    assign all_valid = &pair_ok;
    assign any_err   = |errors;
    assign all_empty = &empties;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RESET;
            error_reg <= '0;
            for (int i = 0; i < NP; i++) begin
                low_reg[i]  <= '0;
                high_reg[i] <= '0;
            end
        end else begin
            // Thresholds follow the inputs on every INIT edge, whatever the next state.
            if (state_reg == ST_INIT) begin
                for (int i = 0; i < NP; i++) begin
                    low_reg[i]  <= low_in[i];
                    high_reg[i] <= high_in[i];
                end
            end
            case (state_reg)
                ST_RESET: state_reg <= ST_INIT;
                ST_INIT: begin
                    if (any_err) begin
                        state_reg <= ST_ERROR;
                        error_reg <= errors;
                    end else if (!init && all_valid) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (any_err) begin
                        state_reg <= ST_ERROR;
                        error_reg <= errors;
                    end else if (init) begin
                        state_reg <= ST_INIT;
                    end else if (!all_empty) begin
                        state_reg <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (any_err) begin
                        state_reg <= ST_ERROR;
                        error_reg <= errors;
                    end else if (init) begin
                        state_reg <= ST_INIT;
                    end else if (all_empty) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ERROR: error_reg <= error_reg | errors;
                default:  state_reg <= ST_RESET;
            endcase
        end
    end

    assign state      = state_reg;
    assign idle_out   = (state_reg == ST_IDLE);
    assign active_out = (state_reg == ST_ACTIVE);
    assign error_out  = error_reg;
    assign cfg_err    = (state_reg == ST_INIT) && !init && !all_valid;

    assign main_fifo_low_out  = low_reg[0];
    assign Vco_low_out        = low_reg[1];
    assign Vc1_low_out        = low_reg[2];
    assign Do_low_out         = low_reg[3];
    assign D1_low_out         = low_reg[4];
    assign main_fifo_high_out = high_reg[0];
    assign Vco_high_out       = high_reg[1];
    assign Vc1_high_out       = high_reg[2];
    assign Do_high_out        = high_reg[3];
    assign D1_high_out        = high_reg[4];

endmodule

// File: tb/tb_fsm_flow_ctrl.sv
// Table-driven bench for fsm_flow_ctrl plus a hand-written asynchronous reset pulse.
module tb_fsm_flow_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init = 1'b0;
    logic [4:0] main_fifo_low = '0, Vco_low = '0, Vc1_low = '0, Do_low = '0, D1_low = '0;
    logic [4:0] main_fifo_high = '0, Vco_high = '0, Vc1_high = '0, Do_high = '0, D1_high = '0;
    logic [4:0] empties = '0, errors = '0;
    logic [4:0] main_fifo_low_out, Vco_low_out, Vc1_low_out, Do_low_out, D1_low_out;
    logic [4:0] main_fifo_high_out, Vco_high_out, Vc1_high_out, Do_high_out, D1_high_out;
    logic [4:0] state;
    logic       cfg_err, idle_out, active_out;
    logic [4:0] error_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fsm_flow_ctrl #(.W(5), .N(5)) dut (
        .clk(clk), .reset(reset), .init(init),
        .main_fifo_low(main_fifo_low), .Vco_low(Vco_low), .Vc1_low(Vc1_low),
        .Do_low(Do_low), .D1_low(D1_low),
        .main_fifo_high(main_fifo_high), .Vco_high(Vco_high), .Vc1_high(Vc1_high),
        .Do_high(Do_high), .D1_high(D1_high),
        .empties(empties), .errors(errors),
        .main_fifo_low_out(main_fifo_low_out), .Vco_low_out(Vco_low_out),
        .Vc1_low_out(Vc1_low_out), .Do_low_out(Do_low_out), .D1_low_out(D1_low_out),
        .main_fifo_high_out(main_fifo_high_out), .Vco_high_out(Vco_high_out),
        .Vc1_high_out(Vc1_high_out), .Do_high_out(Do_high_out), .D1_high_out(D1_high_out),
        .state(state), .cfg_err(cfg_err), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out)
    );

    typedef struct {
        logic        rst;
        logic        ini;
        logic [24:0] lo;
        logic [24:0] hi;
        logic [4:0]  emp;
        logic [4:0]  err;
        logic [4:0]  st;
        logic        cfg;
        logic [4:0]  eo;
        logic [24:0] lo_o;
        logic [24:0] hi_o;
    } vec_t;

    vec_t tbl [24];

    function automatic logic [24:0] pk(input logic [4:0] m, v0, v1, d0, d1);
        return {d1, d0, v1, v0, m};
    endfunction

    function automatic vec_t mk(input logic rst, ini, input logic [24:0] lo, hi,
                                input logic [4:0] emp, err, st, input logic cfg,
                                input logic [4:0] eo, input logic [24:0] lo_o, hi_o);
        vec_t v;
        v.rst = rst; v.ini = ini; v.lo = lo; v.hi = hi; v.emp = emp; v.err = err;
        v.st = st; v.cfg = cfg; v.eo = eo; v.lo_o = lo_o; v.hi_o = hi_o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ini, input logic [24:0] lo, hi, input logic [4:0] emp, err);
        init = ini;
        {D1_low, Do_low, Vc1_low, Vco_low, main_fifo_low} = lo;
        {D1_high, Do_high, Vc1_high, Vco_high, main_fifo_high} = hi;
        empties = emp;
        errors = err;
    endtask

    task automatic check_outs(input string tag, input logic [4:0] st, input logic cfg,
                              input logic [4:0] eo, input logic [24:0] lo_o, hi_o);
        chk({tag, " state"}, 32'(state), 32'(st));
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'(cfg));
        chk({tag, " error_out"}, 32'(error_out), 32'(eo));
        chk({tag, " idle_out"}, 32'(idle_out), 32'(st == 5'b00100));
        chk({tag, " active_out"}, 32'(active_out), 32'(st == 5'b01000));
        chk({tag, " low_outs"},
            32'({D1_low_out, Do_low_out, Vc1_low_out, Vco_low_out, main_fifo_low_out}), 32'(lo_o));
        chk({tag, " high_outs"},
            32'({D1_high_out, Do_high_out, Vc1_high_out, Vco_high_out, main_fifo_high_out}), 32'(hi_o));
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            reset = tbl[i].rst;
            drive(tbl[i].ini, tbl[i].lo, tbl[i].hi, tbl[i].emp, tbl[i].err);
            @(posedge clk);
            #1;
            check_outs($sformatf("row%0d", i), tbl[i].st, tbl[i].cfg, tbl[i].eo,
                       tbl[i].lo_o, tbl[i].hi_o);
            $display("[TB] row %0d: state=%b cfg_err=%b error_out=%b", i, state, cfg_err, error_out);
        end
    endtask

    initial begin
        logic [24:0] z, la, ha, l1, h1, l2, h2, l3, h3, l4, h4, h5;
        z  = '0;
        la = pk(5'd3, 5'hB, 5'hA, 5'h9, 5'hA);
        ha = pk(5'd6, 5'hB, 5'hA, 5'h9, 5'hA);
        l1 = pk(5'd1, 5'd2, 5'd3, 5'd4, 5'd5);
        h1 = pk(5'd7, 5'd7, 5'd7, 5'd7, 5'd7);
        l2 = pk(5'd2, 5'd3, 5'd4, 5'd5, 5'd6);
        h2 = pk(5'd8, 5'd8, 5'd8, 5'd8, 5'd8);
        l3 = pk(5'd6, 5'd5, 5'd4, 5'd3, 5'd2);
        h3 = pk(5'd31, 5'd30, 5'd4, 5'd9, 5'd2);
        l4 = pk(5'd0, 5'd0, 5'd0, 5'd5, 5'd0);
        h4 = pk(5'd0, 5'd0, 5'd0, 5'd4, 5'd0);
        h5 = pk(5'd0, 5'd0, 5'd0, 5'd5, 5'd0);

        //            rst   ini   lo                      hi     emp       err       st        cfg   eo        lo_o  hi_o
        tbl[0]  = mk(1'b0, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00001, 1'b0, 5'b00000, z,    z);
        tbl[1]  = mk(1'b0, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00001, 1'b0, 5'b00000, z,    z);
        tbl[2]  = mk(1'b1, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00010, 1'b0, 5'b00000, z,    z);
        tbl[3]  = mk(1'b1, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00100, 1'b0, 5'b00000, z,    z);
        tbl[4]  = mk(1'b0, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00001, 1'b0, 5'b00000, z,    z);
        tbl[5]  = mk(1'b1, 1'b0, pk(5'd3, 0, 0, 0, 0),   z,     5'b00000, 5'b00000, 5'b00010, 1'b1, 5'b00000, z,    z);
        tbl[6]  = mk(1'b1, 1'b0, pk(5'd3, 0, 0, 0, 0),   z,     5'b00000, 5'b00000, 5'b00010, 1'b1, 5'b00000, pk(5'd3, 0, 0, 0, 0), z);
        tbl[7]  = mk(1'b1, 1'b0, la,                     ha,    5'b00000, 5'b00000, 5'b00100, 1'b0, 5'b00000, la,   ha);
        tbl[8]  = mk(1'b1, 1'b0, z,                      z,     5'b11110, 5'b00000, 5'b01000, 1'b0, 5'b00000, la,   ha);
        tbl[9]  = mk(1'b1, 1'b0, z,                      z,     5'b11111, 5'b00000, 5'b00100, 1'b0, 5'b00000, la,   ha);
        tbl[10] = mk(1'b1, 1'b0, z,                      z,     5'b11110, 5'b00000, 5'b01000, 1'b0, 5'b00000, la,   ha);
        tbl[11] = mk(1'b1, 1'b0, z,                      z,     5'b11110, 5'b00001, 5'b10000, 1'b0, 5'b00001, la,   ha);
        tbl[12] = mk(1'b1, 1'b1, z,                      z,     5'b11111, 5'b00100, 5'b10000, 1'b0, 5'b00101, la,   ha);
        tbl[13] = mk(1'b1, 1'b1, z,                      z,     5'b11111, 5'b00000, 5'b10000, 1'b0, 5'b00101, la,   ha);
        tbl[14] = mk(1'b1, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b00100, 1'b0, 5'b00000, z,    z);
        tbl[15] = mk(1'b1, 1'b1, l1,                     h1,    5'b00000, 5'b00000, 5'b00010, 1'b0, 5'b00000, z,    z);
        tbl[16] = mk(1'b1, 1'b1, l2,                     h2,    5'b00000, 5'b00000, 5'b00010, 1'b0, 5'b00000, l2,   h2);
        tbl[17] = mk(1'b1, 1'b0, l3,                     h3,    5'b00000, 5'b00000, 5'b00100, 1'b0, 5'b00000, l3,   h3);
        tbl[18] = mk(1'b1, 1'b0, z,                      z,     5'b00000, 5'b00000, 5'b01000, 1'b0, 5'b00000, l3,   h3);
        tbl[19] = mk(1'b1, 1'b1, z,                      z,     5'b00000, 5'b00000, 5'b00010, 1'b0, 5'b00000, l3,   h3);
        tbl[20] = mk(1'b1, 1'b0, l4,                     h4,    5'b00000, 5'b00000, 5'b00010, 1'b1, 5'b00000, l4,   h4);
        tbl[21] = mk(1'b1, 1'b0, l4,                     h5,    5'b00000, 5'b00000, 5'b00100, 1'b0, 5'b00000, l4,   h5);
        tbl[22] = mk(1'b1, 1'b1, z,                      z,     5'b00000, 5'b00000, 5'b00010, 1'b0, 5'b00000, l4,   h5);
        tbl[23] = mk(1'b1, 1'b1, z,                      z,     5'b00000, 5'b10000, 5'b10000, 1'b0, 5'b10000, z,    z);

        run_rows(0, 13);

        // Mid-cycle reset pulse from ERROR: takes effect before any clock edge.
        @(negedge clk);
        drive(1'b0, z, z, 5'b00000, 5'b00000);
        #2 reset = 1'b0;
        #1;
        check_outs("async_reset", 5'b00001, 1'b0, 5'b00000, z, z);
        $display("[TB] async reset: state=%b error_out=%b", state, error_out);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_outs("reset_release", 5'b00010, 1'b0, 5'b00000, z, z);
        $display("[TB] reset release: state=%b", state);

        run_rows(14, 23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
